iter_shifter: RTL and testbench
===============================

ITER_SHIFTER -- requirements
Module: iter_shifter

Interface
REQ-001 Parameters: none; width fixed at 16 bits, amount field fixed at 4 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request; sampled on rising clk edges only.
REQ-005 in  input  16  operand, captured when start is accepted.
REQ-006 shift  input  2  op: 00 none, 01 logical left, 10 logical right, 11 arithmetic right (MSB replicated).
REQ-007 amt  input  4  shift distance 0..15, captured when start is accepted.
REQ-008 busy  output  1  high while an operation is in progress (state RUN).
REQ-009 done  output  1  one-cycle pulse marking a valid result.
REQ-010 sout  output  16  result register.

Function
REQ-011 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-012 start SHALL be accepted only in IDLE or DONE; in RUN it SHALL be ignored with no effect on state, counter or sout.
REQ-013 On acceptance, sout SHALL load in, the op SHALL load shift, and the counter SHALL load amt.
REQ-014 If amt==0 or shift==00 at acceptance, the next state SHALL be DONE; otherwise it SHALL be RUN.
REQ-015 Each RUN cycle SHALL shift sout one position per the latched op and decrement the counter.
REQ-016 Exit from RUN to DONE SHALL occur on the cycle the counter reaches 0.
REQ-017 Latency: with start accepted at edge 0, done SHALL be high during cycle amt+1 (cycle 1 for amt==0 or op 00).
REQ-018 done SHALL be high only in DONE, for exactly one cycle; DONE SHALL exit to IDLE, or to RUN/DONE if start is present.
REQ-019 sout SHALL hold the final result from DONE until the next accepted start.
REQ-020 Logical shifts SHALL fill vacated bits with 0; arithmetic right SHALL refill bit 15 with its pre-step value.
REQ-021 Shifted-out bits SHALL be discarded; there SHALL be no carry output.
REQ-022 Input changes on in, shift and amt outside acceptance SHALL have no effect.

Reset
REQ-023 While reset is low: state IDLE, counter 0, sout 16'h0000, busy 0, done 0, applied immediately (asynchronously).
REQ-024 Reset asserted during RUN SHALL abort the operation with no done pulse; the first accepted start after release SHALL behave as from power-up.

Configuration
REQ-025 Macro ITER_SHIFTER_DUAL_STEP_EN: when defined, each RUN cycle SHALL shift by 2 while counter>=2, else by 1, decrementing accordingly.
REQ-026 With ITER_SHIFTER_DUAL_STEP_EN defined, done SHALL occur in cycle ceil(amt/2)+1; when undefined, REQ-017 latency SHALL apply.
REQ-027 Results SHALL be identical with and without the macro; only latency differs.

Structure
REQ-028 Shared package SHALL hold the op encodings (SH_NONE, SH_LSL, SH_LSR, SH_ASR), the FSM state encoding, and the width constants (16, 4).
REQ-029 A combinational sub-module shift_step SHALL implement one step (distance 1, or 1/2 under the macro) per op; iter_shifter SHALL hold the FSM, counter and sout register.

Verification
REQ-030 The bench SHALL cover the following directed scenarios:
- ASR: in=16'h8001, shift=11, amt=3 -> sout=16'hF000, done in cycle 4 (cycle 3 with dual step).
- LSL: in=16'h0003, shift=01, amt=15 -> sout=16'h8000, done in cycle 16 (cycle 9 with dual step); busy high in cycles 1..15.
- LSR, plus a start during RUN: in=16'hFFFF, shift=10, amt=4, second start (in=16'h1234) in cycle 2 -> ignored, sout=16'h0FFF, done in cycle 5.
- Zero cases: in=16'h1234, shift=01, amt=0 -> sout=16'h1234, done cycle 1; shift=00, amt=9 -> sout=16'h1234, done cycle 1.
- Reset mid-RUN: reset low in cycle 2 of an amt=10 op -> sout=16'h0000, busy=0 immediately, no done; next op correct.
- Back-to-back: start held during the DONE cycle -> new op accepted, no IDLE gap, each done exactly one cycle.

Source files
------------

// File: rtl/iter_shifter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iter_shifter_pkg
// Description : Shared widths, shift-op encodings and FSM state encoding for
//               the iterative shifter.
// Revision    : 1.0 - initial release
// ============================================================================
package iter_shifter_pkg;

  localparam int DATA_W = 16;
  localparam int AMT_W  = 4;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL  = 2'b01,
    SH_LSR  = 2'b10,
    SH_ASR  = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/iter_shifter_shift_step.sv
`default_nettype none
// ============================================================================
// Module      : shift_step
// Description : Combinational single-step shifter. Shifts by one position,
//               or by two when 'two' is set, according to the op.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_step
  import iter_shifter_pkg::*;
(
  input  logic [DATA_W-1:0] din,
  input  shift_op_e         op,
  input  logic              two,
  output logic [DATA_W-1:0] dout
);

  // One shift step; vacated bits get 0 for logical ops, the old MSB for ASR
  always_comb begin
    dout = din;
    unique case (op)
      SH_LSL: dout = two ? {din[DATA_W-3:0], 2'b00} : {din[DATA_W-2:0], 1'b0};
      SH_LSR: dout = two ? {2'b00, din[DATA_W-1:2]} : {1'b0, din[DATA_W-1:1]};
      SH_ASR: dout = two ? {{2{din[DATA_W-1]}}, din[DATA_W-1:2]}
                         : {din[DATA_W-1], din[DATA_W-1:1]};
      default: dout = din;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/iter_shifter.sv
`default_nettype none
// ============================================================================
// Module      : iter_shifter
// Description : Iterative 16-bit shifter. A start in IDLE/DONE captures the
//               operand, op and distance; the RUN state then shifts the result
//               register one step per cycle until the counter reaches zero.
//               Optional macro ITER_SHIFTER_DUAL_STEP_EN shifts two positions
//               per cycle while at least two remain (same result, lower
//               latency).
// Revision    : 1.0 - initial release
// ============================================================================
module iter_shifter
  import iter_shifter_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] in,
  input  logic [1:0]        shift,
  input  logic [AMT_W-1:0]  amt,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] sout
);

  state_e            state_q, state_d;
  shift_op_e         op_q, op_d;
  logic [AMT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] sout_q, sout_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              step_two;
  logic [AMT_W-1:0]  step_amt;
  logic [AMT_W-1:0]  cnt_next;
  logic [DATA_W-1:0] step_out;

`ifdef ITER_SHIFTER_DUAL_STEP_EN
  assign step_two = (cnt_q >= AMT_W'(2));
`else
  assign step_two = 1'b0;
`endif

  assign step_amt = step_two ? AMT_W'(2) : AMT_W'(1);
  assign cnt_next = cnt_q - step_amt;

  shift_step u_step (
    .din  (sout_q),
    .op   (op_q),
    .two  (step_two),
    .dout (step_out)
  );

  // Next-state logic: accept start outside RUN, iterate inside RUN
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    sout_d  = sout_q;
    unique case (state_q)
      ST_RUN: begin
        sout_d = step_out;
        cnt_d  = cnt_next;
        if (cnt_next == '0) state_d = ST_DONE;
      end
      default: begin
        if (start) begin
          sout_d  = in;
          op_d    = shift_op_e'(shift);
          cnt_d   = amt;
          state_d = ((amt == '0) || (shift == SH_NONE)) ? ST_DONE : ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State, counter, result and registered status flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      op_q    <= SH_NONE;
      cnt_q   <= '0;
      sout_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      sout_q  <= sout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sout = sout_q;

endmodule
`default_nettype wire

// File: tb/tb_iter_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_iter_shifter
// Description : Scoreboard bench for iter_shifter. Directed operations push
//               their hand-computed result and done cycle into a queue; a
//               monitor pops and compares on every done pulse. Expected
//               latencies follow ITER_SHIFTER_DUAL_STEP_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iter_shifter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] din;
  logic [1:0]  shift;
  logic [3:0]  amt;
  logic        busy;
  logic        done;
  logic [15:0] sout;

  typedef struct {
    logic [15:0] sout;
    int          cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   nb;

  iter_shifter dut (
    .clk   (clk),
    .reset (rst_n),
    .start (start),
    .in    (din),
    .shift (shift),
    .amt   (amt),
    .busy  (busy),
    .done  (done),
    .sout  (sout)
  );

  always #5 clk = ~clk;

  // Cycle index: cycle n of an op is the period after its accept edge + n-1
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done with sout=%h at cycle %0d expected no done", sout, cyc);
      end else begin
        mon_e = q.pop_front();
        check16("sout", sout, mon_e.sout);
        checki("done_cycle", cyc, mon_e.cyc);
      end
    end
  end

  // Drive one request (call at a negedge); returns at the negedge of cycle 1
  task automatic issue(input logic [15:0] d, input logic [1:0] op, input logic [3:0] a,
                       input bit push, input logic [15:0] exp_s,
                       input int lat1, input int lat2);
    int lat;
`ifdef ITER_SHIFTER_DUAL_STEP_EN
    lat = lat2;
`else
    lat = lat1;
`endif
    din   = d;
    shift = op;
    amt   = a;
    start = 1'b1;
    if (push) q.push_back('{sout: exp_s, cyc: cyc + lat});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    checki("drain_pending", q.size(), 0);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) break;
      @(negedge clk);
    end
    checki("wait_done", int'(done), 1);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    din   = '0;
    shift = '0;
    amt   = '0;
    repeat (3) @(negedge clk);
    check16("reset_sout", sout, 16'h0000);
    checki("reset_busy", int'(busy), 0);
    checki("reset_done", int'(done), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // ASR of a negative value
    issue(16'h8001, 2'b11, 4'd3, 1'b1, 16'hF000, 4, 3);
    drain();

    // LSL full distance, count busy cycles
    @(negedge clk);
    issue(16'h0003, 2'b01, 4'd15, 1'b1, 16'h8000, 16, 9);
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) break;
      if (busy === 1'b1) nb++;
      @(negedge clk);
    end
`ifdef ITER_SHIFTER_DUAL_STEP_EN
    checki("busy_cycles", nb, 8);
`else
    checki("busy_cycles", nb, 15);
`endif
    checki("busy_at_done", int'(busy), 0);
    drain();

    // LSR with a second start during RUN that must be ignored
    @(negedge clk);
    issue(16'hFFFF, 2'b10, 4'd4, 1'b1, 16'h0FFF, 5, 3);
    @(negedge clk);
    issue(16'h1234, 2'b01, 4'd0, 1'b0, 16'h0000, 0, 0);
    drain();

    // Zero distance and no-op both finish in cycle 1
    @(negedge clk);
    issue(16'h1234, 2'b01, 4'd0, 1'b1, 16'h1234, 1, 1);
    drain();
    @(negedge clk);
    issue(16'h1234, 2'b00, 4'd9, 1'b1, 16'h1234, 1, 1);
    drain();
    din   = 16'hFFFF;
    shift = 2'b01;
    amt   = 4'd5;
    repeat (3) @(negedge clk);
    check16("hold_sout", sout, 16'h1234);
    checki("hold_busy", int'(busy), 0);

    // Reset in the middle of a long operation
    @(negedge clk);
    issue(16'h5555, 2'b01, 4'd10, 1'b0, 16'h0000, 0, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check16("abort_sout", sout, 16'h0000);
    checki("abort_busy", int'(busy), 0);
    checki("abort_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    issue(16'h00FF, 2'b01, 4'd8, 1'b1, 16'hFF00, 9, 5);
    drain();

    // Back-to-back: new start presented during each DONE cycle
    @(negedge clk);
    issue(16'h00F0, 2'b10, 4'd2, 1'b1, 16'h003C, 3, 2);
    wait_done();
    issue(16'h0001, 2'b01, 4'd1, 1'b1, 16'h0002, 2, 2);
    checki("no_idle_gap_busy", int'(busy), 1);
    wait_done();
    issue(16'hABCD, 2'b01, 4'd0, 1'b1, 16'hABCD, 1, 1);
    @(negedge clk);
    checki("done_single_pulse", int'(done), 0);
    drain();

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
